cp0_nest_exc_ctrl: RTL and testbench

//  Sequences the CP0 primary/nested BadVAddr registers for nested exception support.

---
 rtl/cp0_nest_exc_ctrl_pkg.sv | 27 ++
 rtl/cp0_nest_exc_ctrl_addr_err_arb.sv | 33 +++
 rtl/cp0_nest_exc_ctrl.sv | 149 ++++++++++++++
 tb/tb_cp0_nest_exc_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_nest_exc_ctrl_pkg.sv
// Shared definitions for the CP0 nested BadVAddr sequencer.
// Holds state encodings, address-error ExcCodes and the nesting limit.
package cp0_nest_exc_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_L1   = 2'd1,
      ST_L2   = 2'd2,
      ST_WAIT = 2'd3
   } state_e;

   localparam logic [4:0] EXC_ADEL  = 5'd4;
   localparam logic [4:0] EXC_ADES  = 5'd5;
   localparam logic [1:0] DEPTH_MAX = 2'd2;

   // Level state to resume once the pending request has been acknowledged.
   function automatic state_e level_state(input logic [1:0] depth);
      if (depth >= DEPTH_MAX) begin
         return ST_L2;
      end else if (depth == 2'd1) begin
         return ST_L1;
      end else begin
         return ST_IDLE;
      end
   endfunction

endpackage

// File: rtl/cp0_nest_exc_ctrl_addr_err_arb.sv
// Combinational fixed-priority picker for address-error sources.
// MEM faults are older than IF faults, and stores outrank loads.
module cp0_addr_err_arb
   import cp0_nest_exc_ctrl_pkg::*;
#(
   parameter int         ADDR_W    = 32,
   parameter logic [4:0] CODE_ADEL = EXC_ADEL,
   parameter logic [4:0] CODE_ADES = EXC_ADES
) (
   input  logic              if_err_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              mem_ld_err_i,
   input  logic              mem_st_err_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   output logic              hit_o,
   output logic [4:0]        code_o,
   output logic [ADDR_W-1:0] addr_o
);

   always_comb begin
      hit_o  = mem_st_err_i | mem_ld_err_i | if_err_i;
      code_o = CODE_ADEL;
      addr_o = if_addr_i;
      if (mem_st_err_i) begin
         code_o = CODE_ADES;
         addr_o = mem_addr_i;
      end else if (mem_ld_err_i) begin
         code_o = CODE_ADEL;
         addr_o = mem_addr_i;
      end
   end

endmodule

// File: rtl/cp0_nest_exc_ctrl.sv
// Sequences primary/nested BadVAddr writes and restores for nested exceptions,
// and raises a req/ack exception request towards the pipeline flush logic.
module cp0_nest_exc_ctrl
   import cp0_nest_exc_ctrl_pkg::*;
#(
   parameter int         ADDR_W    = 32,
   parameter logic [4:0] CODE_ADEL = EXC_ADEL,
   parameter logic [4:0] CODE_ADES = EXC_ADES
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              if_err_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              mem_ld_err_i,
   input  logic              mem_st_err_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic              eret_i,
   input  logic              exc_ack_i,
   output logic              bv_wr_p_o,
   output logic              bv_wr_n_o,
   output logic              bv_restore_o,
   output logic [ADDR_W-1:0] bv_data_o,
   output logic              exc_req_o,
   output logic [4:0]        exc_code_o,
   output logic [1:0]        depth_o,
   output logic              nest_ovf_o
);

   state_e              state_q, state_d;
   logic                arb_hit;
   logic [4:0]          arb_code;
   logic [ADDR_W-1:0]   arb_addr;

   logic                wr_p_q, wr_p_d;
   logic                wr_n_q, wr_n_d;
   logic                restore_q, restore_d;
   logic                req_q, req_d;
   logic [4:0]          code_q, code_d;
   logic [ADDR_W-1:0]   data_q, data_d;
   logic [1:0]          depth_q, depth_d;
   logic                ovf_q, ovf_d;

   cp0_addr_err_arb #(
      .ADDR_W    (ADDR_W),
      .CODE_ADEL (CODE_ADEL),
      .CODE_ADES (CODE_ADES)
   ) u_arb (
      .if_err_i     (if_err_i),
      .if_addr_i    (if_addr_i),
      .mem_ld_err_i (mem_ld_err_i),
      .mem_st_err_i (mem_st_err_i),
      .mem_addr_i   (mem_addr_i),
      .hit_o        (arb_hit),
      .code_o       (arb_code),
      .addr_o       (arb_addr)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         wr_p_q    <= 1'b0;
         wr_n_q    <= 1'b0;
         restore_q <= 1'b0;
         req_q     <= 1'b0;
         code_q    <= '0;
         data_q    <= '0;
         depth_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_p_q    <= wr_p_d;
         wr_n_q    <= wr_n_d;
         restore_q <= restore_d;
         req_q     <= req_d;
         code_q    <= code_d;
         data_q    <= data_d;
         depth_q   <= depth_d;
         ovf_q     <= ovf_d;
      end
   end

   // While a request is outstanding, errors and erets are squashed by the flush.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT: begin
            if (exc_ack_i) state_d = level_state(depth_q);
         end
         ST_L2: begin
            if (arb_hit)     state_d = ST_WAIT;
            else if (eret_i) state_d = ST_L1;
         end
         ST_L1: begin
            if (arb_hit)     state_d = ST_WAIT;
            else if (eret_i) state_d = ST_IDLE;
         end
         default: begin
            if (arb_hit)     state_d = ST_WAIT;
         end
      endcase
   end

   always_comb begin
      wr_p_d    = 1'b0;
      wr_n_d    = 1'b0;
      restore_d = 1'b0;
      req_d     = req_q;
      code_d    = code_q;
      data_d    = data_q;
      depth_d   = depth_q;
      ovf_d     = ovf_q;
      if (state_q == ST_WAIT) begin
         if (exc_ack_i) req_d = 1'b0;
      end else if (arb_hit) begin
         req_d  = 1'b1;
         code_d = arb_code;
         data_d = arb_addr;
         case (state_q)
            ST_IDLE: begin
               wr_p_d  = 1'b1;
               depth_d = 2'd1;
            end
            ST_L1: begin
               wr_n_d  = 1'b1;
               depth_d = DEPTH_MAX;
            end
            default: ovf_d = 1'b1;
         endcase
      end else if (eret_i) begin
         if (state_q == ST_L2) begin
            restore_d = 1'b1;
            depth_d   = 2'd1;
         end else if (state_q == ST_L1) begin
            depth_d   = 2'd0;
            ovf_d     = 1'b0;
         end
      end
   end

   assign bv_wr_p_o    = wr_p_q;
   assign bv_wr_n_o    = wr_n_q;
   assign bv_restore_o = restore_q;
   assign bv_data_o    = data_q;
   assign exc_req_o    = req_q;
   assign exc_code_o   = code_q;
   assign depth_o      = depth_q;
   assign nest_ovf_o   = ovf_q;

endmodule

// File: tb/tb_cp0_nest_exc_ctrl.sv
// Directed bench for cp0_nest_exc_ctrl: nesting, priority, handshake and reset.
module tb_cp0_nest_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        if_err = 1'b0;
   logic [31:0] if_addr = '0;
   logic        mem_ld_err = 1'b0;
   logic        mem_st_err = 1'b0;
   logic [31:0] mem_addr = '0;
   logic        eret = 1'b0;
   logic        exc_ack = 1'b0;
   logic        bv_wr_p, bv_wr_n, bv_restore, exc_req, nest_ovf;
   logic [31:0] bv_data;
   logic [4:0]  exc_code;
   logic [1:0]  depth;
   logic [11:0] flags;
   logic [11:0] exp;

   int n_chk = 0;
   int n_fail = 0;

   assign flags = {bv_wr_p, bv_wr_n, bv_restore, exc_req, exc_code, depth, nest_ovf};

   cp0_nest_exc_ctrl #(.ADDR_W(32)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .if_err_i     (if_err),
      .if_addr_i    (if_addr),
      .mem_ld_err_i (mem_ld_err),
      .mem_st_err_i (mem_st_err),
      .mem_addr_i   (mem_addr),
      .eret_i       (eret),
      .exc_ack_i    (exc_ack),
      .bv_wr_p_o    (bv_wr_p),
      .bv_wr_n_o    (bv_wr_n),
      .bv_restore_o (bv_restore),
      .bv_data_o    (bv_data),
      .exc_req_o    (exc_req),
      .exc_code_o   (exc_code),
      .depth_o      (depth),
      .nest_ovf_o   (nest_ovf)
   );

   always #5 clk = ~clk;

   // Expected flag vector: {wr_p, wr_n, restore, req, code, depth, ovf}
   function automatic logic [11:0] fv(input bit p, input bit n, input bit r, input bit q,
                                      input logic [4:0] c, input logic [1:0] d, input bit o);
      return {p, n, r, q, c, d, o};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      if_err = 0; mem_ld_err = 0; mem_st_err = 0; eret = 0; exc_ack = 0;
   endtask

   task automatic pulse_ack();
      exc_ack = 1; step(); exc_ack = 0;
   endtask

   task automatic test_reset();
      n_chk++;
      if (flags !== 12'h000) begin
         n_fail++; $display("FAIL reset_flags act=%h exp=%h", flags, 12'h000);
      end
      n_chk++;
      if (bv_data !== 32'h0) begin
         n_fail++; $display("FAIL reset_data act=%h exp=%h", bv_data, 32'h0);
      end
      step(); step();
      rst_n = 1;
      step();
      n_chk++;
      if (flags !== 12'h000) begin
         n_fail++; $display("FAIL reset_release act=%h exp=%h", flags, 12'h000);
      end
   endtask

   task automatic test_if_err();
      if_err = 1; if_addr = 32'h0040_0001;
      step(); clear_in();
      exp = fv(1, 0, 0, 1, 5'd4, 2'd1, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL if_err_flags act=%h exp=%h", flags, exp); end
      n_chk++;
      if (bv_data !== 32'h0040_0001) begin n_fail++; $display("FAIL if_err_data act=%h exp=%h", bv_data, 32'h0040_0001); end
      step();
      exp = fv(0, 0, 0, 1, 5'd4, 2'd1, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL if_err_pulse act=%h exp=%h", flags, exp); end
      pulse_ack();
      exp = fv(0, 0, 0, 0, 5'd4, 2'd1, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL if_err_ack act=%h exp=%h", flags, exp); end
      eret = 1; step(); eret = 0;
      exp = fv(0, 0, 0, 0, 5'd4, 2'd0, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL if_err_eret act=%h exp=%h", flags, exp); end
      exc_ack = 1; eret = 1; step(); clear_in();
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL idle_ignore act=%h exp=%h", flags, exp); end
   endtask

   task automatic test_priority();
      mem_st_err = 1; if_err = 1; mem_addr = 32'h8000_0003; if_addr = 32'h0000_1234;
      step(); clear_in();
      exp = fv(1, 0, 0, 1, 5'd5, 2'd1, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL prio_flags act=%h exp=%h", flags, exp); end
      n_chk++;
      if (bv_data !== 32'h8000_0003) begin n_fail++; $display("FAIL prio_data act=%h exp=%h", bv_data, 32'h8000_0003); end
      pulse_ack();
      exp = fv(0, 0, 0, 0, 5'd5, 2'd1, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL prio_ack act=%h exp=%h", flags, exp); end
   endtask

   task automatic test_nest();
      mem_ld_err = 1; if_err = 1; mem_addr = 32'h0000_1002; if_addr = 32'h0000_0bad;
      step(); clear_in();
      exp = fv(0, 1, 0, 1, 5'd4, 2'd2, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL nest_flags act=%h exp=%h", flags, exp); end
      n_chk++;
      if (bv_data !== 32'h0000_1002) begin n_fail++; $display("FAIL nest_data act=%h exp=%h", bv_data, 32'h0000_1002); end
      pulse_ack();
      eret = 1; step(); eret = 0;
      exp = fv(0, 0, 1, 0, 5'd4, 2'd1, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL nest_restore act=%h exp=%h", flags, exp); end
      step();
      exp = fv(0, 0, 0, 0, 5'd4, 2'd1, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL nest_restore_pulse act=%h exp=%h", flags, exp); end
      eret = 1; step(); eret = 0;
      exp = fv(0, 0, 0, 0, 5'd4, 2'd0, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL nest_eret0 act=%h exp=%h", flags, exp); end
   endtask

   task automatic test_overflow();
      if_err = 1; if_addr = 32'h100; step(); clear_in(); pulse_ack();
      if_err = 1; if_addr = 32'h200; step(); clear_in();
      exp = fv(0, 1, 0, 1, 5'd4, 2'd2, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL ovf_lvl2 act=%h exp=%h", flags, exp); end
      pulse_ack();
      if_err = 1; if_addr = 32'h300; step(); clear_in();
      exp = fv(0, 0, 0, 1, 5'd4, 2'd2, 1);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL ovf_set act=%h exp=%h", flags, exp); end
      n_chk++;
      if (bv_data !== 32'h300) begin n_fail++; $display("FAIL ovf_data act=%h exp=%h", bv_data, 32'h300); end
      pulse_ack();
      eret = 1; step(); eret = 0;
      exp = fv(0, 0, 1, 0, 5'd4, 2'd1, 1);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL ovf_sticky act=%h exp=%h", flags, exp); end
      eret = 1; step(); eret = 0;
      exp = fv(0, 0, 0, 0, 5'd4, 2'd0, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL ovf_clear act=%h exp=%h", flags, exp); end
   endtask

   task automatic test_hold();
      mem_st_err = 1; mem_addr = 32'h0000_00a0; step(); clear_in();
      exp = fv(1, 0, 0, 1, 5'd5, 2'd1, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL hold_start act=%h exp=%h", flags, exp); end
      exp = fv(0, 0, 0, 1, 5'd5, 2'd1, 0);
      for (int i = 0; i < 5; i++) begin
         if_err = 1; if_addr = 32'h5000 + i;
         mem_ld_err = i[0]; mem_addr = 32'h6000 + i;
         eret = (i == 2);
         step();
         n_chk++;
         if (flags !== exp) begin n_fail++; $display("FAIL hold_flags[%0d] act=%h exp=%h", i, flags, exp); end
         n_chk++;
         if (bv_data !== 32'h0000_00a0) begin n_fail++; $display("FAIL hold_data[%0d] act=%h exp=%h", i, bv_data, 32'h0000_00a0); end
      end
      clear_in();
      pulse_ack();
      exp = fv(0, 0, 0, 0, 5'd5, 2'd1, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL hold_ack act=%h exp=%h", flags, exp); end
   endtask

   task automatic test_same_cycle_and_reset();
      eret = 1; mem_ld_err = 1; mem_addr = 32'h0000_2004; step(); clear_in();
      exp = fv(0, 1, 0, 1, 5'd4, 2'd2, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL same_cycle act=%h exp=%h", flags, exp); end
      n_chk++;
      if (bv_data !== 32'h0000_2004) begin n_fail++; $display("FAIL same_cycle_data act=%h exp=%h", bv_data, 32'h0000_2004); end
      #2 rst_n = 0;
      #1;
      n_chk++;
      if (flags !== 12'h000) begin n_fail++; $display("FAIL async_rst_flags act=%h exp=%h", flags, 12'h000); end
      n_chk++;
      if (bv_data !== 32'h0) begin n_fail++; $display("FAIL async_rst_data act=%h exp=%h", bv_data, 32'h0); end
      step();
      rst_n = 1;
      if_err = 1; if_addr = 32'h0000_0777; step(); clear_in();
      exp = fv(1, 0, 0, 1, 5'd4, 2'd1, 0);
      n_chk++;
      if (flags !== exp) begin n_fail++; $display("FAIL post_rst act=%h exp=%h", flags, exp); end
   endtask

   initial begin
      #2 rst_n = 0;
      #1;
      test_reset();
      test_if_err();
      test_priority();
      test_nest();
      test_overflow();
      test_hold();
      test_same_cycle_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
